retire_trace: RTL and testbench

- Captures architectural state at the retirement of every CPU instruction.
- Retirement is the last T-cycle of the last M-cycle of an instruction.
- Each captured record is the retired opcode concatenated with the 64-bit register snapshot {A,B,C,D,E,H,L,F}. Records are buffered in a show-ahead FIFO and drained over a valid/ready interface.
- Sits directly downstream of the decoder (d1) and register file (r1) inside top. It feeds a debug port and the self-checking bench, replacing hierarchical peeking.

---
 rtl/retire_trace_if.sv | 12 +
 rtl/retire_trace.sv | 116 +++++++++++
 tb/tb_retire_trace.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/retire_trace_if.sv
// Valid/ready stream carrying retired-instruction trace records.
// The master drives the valid and data signals, and the slave drives ready.
interface retire_trace_if #(
    parameter int unsigned DATA_W = 72
) ();
    logic              trace_valid;
    logic              trace_ready;
    logic [DATA_W-1:0] trace_data;

    modport master (output trace_valid, output trace_data, input trace_ready);
    modport slave  (input trace_valid, input trace_data, output trace_ready);
endinterface

// File: rtl/retire_trace.sv
// Captures {opcode, register snapshot} at every instruction retirement into a
// show-ahead FIFO. The FIFO is drained over a valid/ready trace stream.
module retire_trace #(
    parameter int unsigned          DEPTH    = 8,
    parameter int unsigned          OP_SIZE  = 8,
    parameter int unsigned          RES_SIZE = 64,
    parameter logic [OP_SIZE-1:0]   STOP_OP  = 8'h10
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        clr,
    input  logic [1:0]                  t_cycle,
    input  logic [2:0]                  m_cycle,
    input  logic [2:0]                  m_count,
    input  logic                        hold,
    input  logic [OP_SIZE-1:0]          instruction,
    input  logic [RES_SIZE-1:0]         regs,
    retire_trace_if.master              trace,
    output logic [$clog2(DEPTH):0]      level,
    output logic [31:0]                 retired_count,
    output logic [15:0]                 dropped_count,
    output logic                        overflow,
    output logic                        stop_seen
);
    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned REC_W = OP_SIZE + RES_SIZE;

    logic [REC_W-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    rd_next;
    logic [AW:0]      level_next;
    logic [REC_W-1:0] record;
    logic [REC_W-1:0] head_next;
    logic [REC_W-1:0] data_q;
    logic             ret;
    logic             ret_q;
    logic             push_att;
    logic             full;
    logic             pop;
    logic             wr;
    logic             drop;

    always_comb begin
        record     = {instruction, regs};
        ret        = (t_cycle == 2'b11) && ((m_count - m_cycle) == 3'd1)
                     && !hold && !stop_seen;
        push_att   = ret && !ret_q;
        full       = (level == (AW+1)'(DEPTH));
        pop        = trace.trace_valid && trace.trace_ready;
        wr         = push_att && (!full || pop);
        drop       = push_att && full && !pop;
        rd_next    = rd_ptr + AW'(pop);
        level_next = level + (AW+1)'(wr) - (AW+1)'(pop);
        // The registered head must take the incoming record directly when it
        // lands in the slot that becomes the head on this edge.
        head_next  = (wr && (wr_ptr == rd_next)) ? record : mem[rd_next];
    end

    always_ff @(posedge clk) begin
        if (wr && !clr) begin
            mem[wr_ptr] <= record;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            level         <= '0;
            data_q        <= '0;
            ret_q         <= 1'b0;
            retired_count <= '0;
            dropped_count <= '0;
            overflow      <= 1'b0;
            stop_seen     <= 1'b0;
        end else if (clr) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            level         <= '0;
            data_q        <= '0;
            ret_q         <= 1'b0;
            retired_count <= '0;
            dropped_count <= '0;
            overflow      <= 1'b0;
            stop_seen     <= 1'b0;
        end else begin
            ret_q <= ret;
            level <= level_next;
            if (wr) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_next;
            end
            if (level_next != '0) begin
                data_q <= head_next;
            end
            if (push_att) begin
                retired_count <= retired_count + 32'd1;
                if (instruction == STOP_OP) begin
                    stop_seen <= 1'b1;
                end
            end
            if (drop) begin
                overflow <= 1'b1;
                if (dropped_count != 16'hFFFF) begin
                    dropped_count <= dropped_count + 16'd1;
                end
            end
        end
    end

    assign trace.trace_valid = (level != '0);
    assign trace.trace_data  = data_q;
endmodule

// File: tb/tb_retire_trace.sv
// Scoreboard bench for retire_trace: expected records are queued at retire
// time and compared against the trace stream at each handshake.
module tb_retire_trace;
    typedef logic [71:0] rec_t;

    logic        clk;
    logic        rst;
    logic        clr;
    logic [1:0]  t_cycle;
    logic [2:0]  m_cycle;
    logic [2:0]  m_count;
    logic        hold;
    logic [7:0]  instruction;
    logic [63:0] regs;
    logic [3:0]  level;
    logic [31:0] retired_count;
    logic [15:0] dropped_count;
    logic        overflow;
    logic        stop_seen;

    int tests_run;
    int failed;
    rec_t sb[$];

    retire_trace_if #(.DATA_W(72)) trace_bus ();

    retire_trace #(
        .DEPTH(8), .OP_SIZE(8), .RES_SIZE(64), .STOP_OP(8'h10)
    ) dut (
        .clk(clk), .rst(rst), .clr(clr),
        .t_cycle(t_cycle), .m_cycle(m_cycle), .m_count(m_count),
        .hold(hold), .instruction(instruction), .regs(regs),
        .trace(trace_bus),
        .level(level), .retired_count(retired_count),
        .dropped_count(dropped_count), .overflow(overflow),
        .stop_seen(stop_seen)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock: score any handshake at the falling edge, return just after the rising edge.
    task automatic step();
        rec_t exp;
        @(negedge clk);
        if (trace_bus.trace_valid && trace_bus.trace_ready) begin
            tests_run++;
            if (sb.size() == 0) begin
                failed++;
                $display("FAIL unexpected_record got=%h expected=none", trace_bus.trace_data);
            end else begin
                exp = sb.pop_front();
                if (trace_bus.trace_data !== exp) begin
                    failed++;
                    $display("FAIL record got=%h expected=%h", trace_bus.trace_data, exp);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic retire(input logic [7:0] op, input logic [63:0] r, input bit expect_push);
        t_cycle = 2'b11; m_cycle = 3'd2; m_count = 3'd3; hold = 1'b0;
        instruction = op; regs = r;
        if (expect_push) sb.push_back({op, r});
        step();
        t_cycle = 2'b00;
        step();
    endtask

    task automatic drain();
        trace_bus.trace_ready = 1'b1;
        for (int i = 0; i < 64 && sb.size() != 0; i++) step();
        trace_bus.trace_ready = 1'b0;
        tests_run++;
        if (sb.size() != 0) begin
            failed++;
            $display("FAIL drain_timeout left=%0d expected=0", sb.size());
        end
        tests_run++;
        if (level !== 4'd0) begin
            failed++;
            $display("FAIL drain_level got=%0d expected=0", level);
        end
    endtask

    task automatic do_clr();
        clr = 1'b1;
        step();
        clr = 1'b0;
        sb.delete();
    endtask

    task automatic test_reset();
        #3;
        tests_run++;
        if ({trace_bus.trace_valid, level, retired_count, dropped_count, overflow, stop_seen} !== '0
            || trace_bus.trace_data !== '0) begin
            failed++;
            $display("FAIL reset_state valid=%b level=%0d ret=%0d drop=%0d ovf=%b stop=%b data=%h expected=all_zero",
                     trace_bus.trace_valid, level, retired_count, dropped_count, overflow, stop_seen,
                     trace_bus.trace_data);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        step();
    endtask

    task automatic test_basic();
        trace_bus.trace_ready = 1'b1;
        retire(8'h3E, 64'h1200_0000_0000_0000, 1'b1);
        retire(8'h47, 64'h1212_0000_0000_0000, 1'b1);
        retire(8'h00, 64'h1212_0000_0000_0000, 1'b1);
        trace_bus.trace_ready = 1'b0;
        tests_run++;
        if (sb.size() != 0 || level !== 4'd0) begin
            failed++;
            $display("FAIL basic_drained left=%0d level=%0d expected=0", sb.size(), level);
        end
        tests_run++;
        if (retired_count !== 32'd3 || dropped_count !== 16'd0 || overflow !== 1'b0) begin
            failed++;
            $display("FAIL basic_counts ret=%0d drop=%0d ovf=%b expected=3,0,0",
                     retired_count, dropped_count, overflow);
        end
    endtask

    task automatic test_overflow();
        do_clr();
        for (int i = 0; i < 10; i++)
            retire(8'h20 + 8'(i), {$urandom, $urandom}, i < 8);
        tests_run++;
        if (level !== 4'd8 || dropped_count !== 16'd2 || overflow !== 1'b1 || retired_count !== 32'd10) begin
            failed++;
            $display("FAIL overflow_state level=%0d drop=%0d ovf=%b ret=%0d expected=8,2,1,10",
                     level, dropped_count, overflow, retired_count);
        end
    endtask

    task automatic test_full_push_pop();
        trace_bus.trace_ready = 1'b1;
        t_cycle = 2'b11; m_cycle = 3'd2; m_count = 3'd3; hold = 1'b0;
        instruction = 8'h5A; regs = {$urandom, $urandom};
        sb.push_back({instruction, regs});
        step();
        trace_bus.trace_ready = 1'b0;
        t_cycle = 2'b00;
        tests_run++;
        if (level !== 4'd8 || dropped_count !== 16'd2 || retired_count !== 32'd11) begin
            failed++;
            $display("FAIL full_push_pop level=%0d drop=%0d ret=%0d expected=8,2,11",
                     level, dropped_count, retired_count);
        end
        step();
        drain();
    endtask

    task automatic test_hold();
        do_clr();
        // Modular M-cycle difference: 0 - 7 == 1 in 3 bits.
        t_cycle = 2'b11; m_cycle = 3'd7; m_count = 3'd0; hold = 1'b1;
        instruction = 8'h04; regs = {$urandom, $urandom};
        repeat (3) step();
        tests_run++;
        if (level !== 4'd0 || retired_count !== 32'd0) begin
            failed++;
            $display("FAIL hold_stall level=%0d ret=%0d expected=0,0", level, retired_count);
        end
        hold = 1'b0;
        sb.push_back({instruction, regs});
        step();
        step();
        tests_run++;
        if (level !== 4'd1 || retired_count !== 32'd1) begin
            failed++;
            $display("FAIL hold_release level=%0d ret=%0d expected=1,1", level, retired_count);
        end
        t_cycle = 2'b00;
        step();
        t_cycle = 2'b11; m_cycle = 3'd1; m_count = 3'd3;
        step();
        t_cycle = 2'b00;
        step();
        tests_run++;
        if (retired_count !== 32'd1) begin
            failed++;
            $display("FAIL non_final_mcycle ret=%0d expected=1", retired_count);
        end
        drain();
    endtask

    task automatic test_stop();
        do_clr();
        retire(8'h10, {$urandom, $urandom}, 1'b1);
        retire(8'h30, {$urandom, $urandom}, 1'b0);
        retire(8'h31, {$urandom, $urandom}, 1'b0);
        tests_run++;
        if (stop_seen !== 1'b1 || retired_count !== 32'd1 || level !== 4'd1) begin
            failed++;
            $display("FAIL stop_state stop=%b ret=%0d level=%0d expected=1,1,1",
                     stop_seen, retired_count, level);
        end
        drain();
        do_clr();
        tests_run++;
        if (stop_seen !== 1'b0 || level !== 4'd0 || retired_count !== 32'd0 || dropped_count !== 16'd0) begin
            failed++;
            $display("FAIL clr_state stop=%b level=%0d ret=%0d drop=%0d expected=0,0,0,0",
                     stop_seen, level, retired_count, dropped_count);
        end
    endtask

    task automatic test_async_reset();
        do_clr();
        for (int i = 0; i < 9; i++)
            retire(8'h40 + 8'(i), {$urandom, $urandom}, i < 8);
        trace_bus.trace_ready = 1'b1;
        repeat (3) step();
        trace_bus.trace_ready = 1'b0;
        tests_run++;
        if (level !== 4'd5 || overflow !== 1'b1) begin
            failed++;
            $display("FAIL pre_reset level=%0d ovf=%b expected=5,1", level, overflow);
        end
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        tests_run++;
        if ({trace_bus.trace_valid, level, retired_count, dropped_count, overflow, stop_seen} !== '0
            || trace_bus.trace_data !== '0) begin
            failed++;
            $display("FAIL async_reset valid=%b level=%0d ret=%0d drop=%0d ovf=%b data=%h expected=all_zero",
                     trace_bus.trace_valid, level, retired_count, dropped_count, overflow,
                     trace_bus.trace_data);
        end
        sb.delete();
        @(posedge clk);
        #1;
        rst = 1'b1;
        step();
        t_cycle = 2'b11; m_cycle = 3'd2; m_count = 3'd3; hold = 1'b0;
        instruction = 8'h77; regs = {$urandom, $urandom};
        sb.push_back({instruction, regs});
        step();
        t_cycle = 2'b00;
        tests_run++;
        if (level !== 4'd1 || trace_bus.trace_valid !== 1'b1) begin
            failed++;
            $display("FAIL post_reset_push level=%0d valid=%b expected=1,1", level, trace_bus.trace_valid);
        end
        step();
        drain();
    endtask

    initial begin
        tests_run = 0;
        failed = 0;
        rst = 1'b0;
        clr = 1'b0;
        t_cycle = 2'b00;
        m_cycle = 3'd0;
        m_count = 3'd0;
        hold = 1'b0;
        instruction = 8'h00;
        regs = '0;
        trace_bus.trace_ready = 1'b0;

        test_reset();
        test_basic();
        test_overflow();
        test_full_push_pop();
        test_hold();
        test_stop();
        test_async_reset();

        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end
endmodule
